// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard encoder.
//   PS2_EXT / PS2_REL / PS2_PAUSE : prefix scancodes (E0, F0, E1)
//   PS2_PAUSE_SKIP                : bytes following E1 that form the pause sequence
//   frame_state_e                 : serial frame FSM states
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_REL        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

endpackage

// File: rtl/ps2_pin_filter.sv
// ps2_pin_filter: conditions one asynchronous PS/2 pin.
//   A 2-flop synchroniser feeds a counter filter; the filtered output only
//   changes after FILTER_LEN consecutive synchronised samples disagree with it.
//   Everything resets to 1, the idle level of the open-collector bus.
// Ports:
//   i_clk   in  system clock
//   i_rst_n in  asynchronous active-low reset
//   i_pin   in  raw pin (asynchronous)
//   o_pin   out filtered, synchronous pin level
module ps2_pin_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_pin
);
    import ps2_pkg::*;

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_filt  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_pin;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_filt) begin
                // Any agreeing sample restarts the run, so short glitches vanish.
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_filt <= r_sync1;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pin = r_filt;

endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: turns the raw PS/2 keyboard stream into the 11-bit ps2_key
// event word {toggle, pressed, extended, scancode}.
// Ports:
//   clk_sys   in  system clock (only clock)
//   reset_n   in  asynchronous active-low reset
//   ps2_clk   in  raw PS/2 clock pin
//   ps2_data  in  raw PS/2 data pin
//   ps2_key   out event word; bit 10 flips on every event, value held between events
//   frame_err out one-cycle pulse on parity error, stop-bit error or timeout
//   busy      out high while a frame is being received
// Handshake: there is no ready/valid; an event is the cycle in which
// ps2_key[10] changes, and the consumer must observe every change.
module ps2_key_encoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          w_clk_f;
    logic          w_data_f;

    logic          r_clk_d;
    logic          r_fall;
    logic          r_fall_data;

    frame_state_e  r_state;
    frame_state_e  w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_tmo_cnt;

    logic          r_ext;
    logic          r_rel;
    logic [2:0]    r_skip;
    logic [10:0]   r_key;
    logic          r_frame_err;

    logic          w_accept;
    logic          w_bad;
    logic          w_timeout;

    ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_pin   (ps2_clk),
        .o_pin   (w_clk_f)
    );

    ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_pin   (ps2_data),
        .o_pin   (w_data_f)
    );

    // Registered falling-edge strobe; the data level is captured alongside so
    // the FSM sees the bit value that was present at the edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_d     <= 1'b1;
            r_fall      <= 1'b0;
            r_fall_data <= 1'b1;
        end else begin
            r_clk_d     <= w_clk_f;
            r_fall      <= r_clk_d & ~w_clk_f;
            r_fall_data <= w_data_f;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_bad       = 1'b0;
        w_timeout   = 1'b0;
        // A fall on the same cycle as the timeout wins, so the timeout is
        // qualified with ~r_fall.
        if (r_state != IDLE && !r_fall && r_tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
        end else if (r_fall) begin
            case (r_state)
                IDLE: begin
                    if (!r_fall_data) begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    // Odd parity: data bits plus parity bit hold an odd count of ones.
                    if (r_fall_data && (^{r_shift, r_parity})) begin
                        w_accept = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Shifter, parity latch and timeout counter.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            if (r_fall || r_state == IDLE || w_timeout) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (r_fall) begin
                case (r_state)
                    IDLE:   r_bit_cnt <= '0;
                    DATA: begin
                        r_shift   <= {r_fall_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    PARITY: r_parity <= r_fall_data;
                    default: ;
                endcase
            end
        end
    end

    // Prefix tracking and event generation.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_skip      <= '0;
            r_key       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad | w_timeout;
            if (w_bad) begin
                r_ext  <= 1'b0;
                r_rel  <= 1'b0;
                r_skip <= '0;
            end else if (w_timeout) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else if (w_accept) begin
                if (r_skip != 3'd0) begin
                    // Inside the pause sequence: drop the byte, flags untouched.
                    r_skip <= r_skip - 3'd1;
                end else if (r_shift == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == PS2_REL) begin
                    r_rel <= 1'b1;
                end else if (r_shift == PS2_PAUSE) begin
                    r_skip <= PS2_PAUSE_SKIP;
                end else begin
                    r_key <= {~r_key[10], ~r_rel, r_ext, r_shift};
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end
            end
        end
    end

    assign ps2_key   = r_key;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_key_encoder.sv
module tb_ps2_key_encoder;

    localparam int FLEN = 8;
    localparam int TMO  = 2000;
    localparam int H    = 20;    // half bit period in clk_sys cycles

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_cycles = 0;
    logic        busy_seen = 1'b0;
    logic [10:0] prev_key = '0;

    ps2_key_encoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    // scoreboard monitor: every change of ps2_key is an event popped from exp_q
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key <= '0;
        end else begin
            if (frame_err) err_cycles <= err_cycles + 1;
            if (busy) busy_seen <= 1'b1;
            if (ps2_key !== prev_key) begin
                logic [10:0] e;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $error("FAIL unexpected_event: got %h required no event", ps2_key);
                end else begin
                    e = exp_q.pop_front();
                    assert (ps2_key === e) else begin
                        n_fail++;
                        $error("FAIL event: got %h required %h", ps2_key, e);
                    end
                end
                prev_key <= ps2_key;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (H) @(posedge clk_sys);
        ps2_clk = 1'b0;
        repeat (H) @(posedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~(^code) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (2 * H) @(posedge clk_sys);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk_sys);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int e0;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset_key", ps2_key, 0);
        check("reset_err", frame_err, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);

        // single make
        exp_q.push_back(11'h629);
        send_frame(8'h29, 1'b0);
        drain("make_29");
        // break
        exp_q.push_back(11'h029);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        drain("break_29");
        // extended make / break
        exp_q.push_back(11'h775);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        drain("ext_make_75");
        exp_q.push_back(11'h175);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        drain("ext_break_75");
        check("no_err_so_far", err_cycles, 0);

        // parity error
        e0 = err_cycles;
        send_frame(8'h1C, 1'b1);
        @(negedge clk_sys);
        check("parity_err_pulse", err_cycles - e0, 1);
        check("parity_key_held", ps2_key, 11'h175);
        exp_q.push_back(11'h61C);
        send_frame(8'h1C, 1'b0);
        drain("after_parity_1C");

        // timeout after 4 data bits
        e0 = err_cycles;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk_sys);
        check("busy_mid_frame", busy, 1);
        repeat (TMO + 100) @(posedge clk_sys);
        @(negedge clk_sys);
        check("timeout_err_pulse", err_cycles - e0, 1);
        check("timeout_busy_low", busy, 0);
        exp_q.push_back(11'h229);
        send_frame(8'h29, 1'b0);
        drain("after_timeout_29");

        // 3-cycle ps2_clk glitch with data low must not start a frame
        ps2_data = 1'b0;
        repeat (H) @(posedge clk_sys);
        @(negedge clk_sys);
        busy_seen = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (50) @(posedge clk_sys);
        @(negedge clk_sys);
        check("glitch_no_busy", busy_seen, 0);
        ps2_data = 1'b1;
        repeat (H) @(posedge clk_sys);

        // pause sequence produces no events
        e0 = err_cycles;
        send_frame(8'hE1, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'h77, 1'b0);
        send_frame(8'hE1, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h77, 1'b0);
        @(negedge clk_sys);
        check("pause_key_held", ps2_key, 11'h229);
        exp_q.push_back(11'h629);
        send_frame(8'h29, 1'b0);
        drain("after_pause_29");
        check("pause_no_err", err_cycles - e0, 0);

        // reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ps2_data = 1'b0;
        repeat (H) @(posedge clk_sys);
        ps2_clk = 1'b0;
        repeat (H / 2) @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_key", ps2_key, 0);
        check("midreset_err", frame_err, 0);
        check("midreset_busy", busy, 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        e0 = err_cycles;
        repeat (4 * H) @(posedge clk_sys);
        check("postreset_no_err", err_cycles - e0, 0);
        exp_q.push_back(11'h629);
        send_frame(8'h29, 1'b0);
        drain("postreset_29");

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_encoder.md
# ps2_key_encoder

Converts the raw PS/2 keyboard serial stream into the 11-bit `ps2_key` event word that arcade cores decode for player controls. The word carries a toggle bit, a pressed flag, an extended flag and the scancode. The block sits on the keyboard side of that interface and is the producer of the word each core's key decoder consumes. It deglitches the PS/2 pins, deserialises 11-bit frames, checks parity and stop bit, and tracks E0/F0/E1 prefixes. It emits one event word per completed make or break code.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical `clk_sys` samples needed before a filtered pin changes.
- `TIMEOUT_CYCLES`, default 50000: idle `clk_sys` cycles inside a frame after which the partial frame is discarded.
- `clk_sys`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `ps2_key`  out  11  event word:
  - [10] toggle, which flips on every event;
  - [9] pressed (1 = make, 0 = break);
  - [8] extended (E0 prefix seen);
  - [7:0] scancode.
- `frame_err`  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.
- `busy`  out  1  high while a frame is in progress.

## Operation
- **Pin conditioning.** Each pin goes through a 2-flop synchroniser, then a counter filter. The filtered value changes only after `FILTER_LEN` equal samples.
- **Clock edge.** `fall` is a one-cycle strobe on each filtered `ps2_clk` 1→0 edge. Data is sampled from the filtered `ps2_data` on `fall`.
- **Frame FSM.**
  - IDLE: on `fall` with data = 0 (start bit), go to DATA. With data = 1, stay in IDLE and ignore the edge.
  - DATA: shift 8 bits in, LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: on `fall`, go back to IDLE. The byte is accepted only if the stop bit = 1 and data XOR parity has odd parity (odd overall). Otherwise pulse `frame_err` and discard the byte.
- **Timeout.** The counter resets on every `fall` and counts only when the FSM is not in IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `frame_err` pulses and the prefix flags clear.
- **Prefix handling for an accepted byte.**
  - E0: set `ext`; no event.
  - F0: set `rel`; no event.
  - E1: load `skip` = 7. The following 7 accepted bytes are dropped without events and without changing the flags (pause sequence).
  - Any other byte with `skip` = 0: update `ps2_key` to {~ps2_key[10], ~rel, ext, byte}, then clear `ext` and `rel`.
- **Error clearing.** A parity or stop error also clears `ext`, `rel` and `skip`.
- **`busy`.** High in DATA, PARITY and STOP.

## Timing
- **Reset values.** While `reset_n` is low, everything clears asynchronously:
  - `ps2_key` = 0, `frame_err` = 0, `busy` = 0;
  - FSM in IDLE;
  - flags and `skip` = 0;
  - both filters at 1 (idle bus level).
- **Edge-detect latency.** `fall` asserts `FILTER_LEN`+3 cycles after a clean pin edge: 2 synchroniser cycles plus the filter count plus 1 edge register.
- **Event latency.** `ps2_key` updates in the cycle after the `fall` that samples the stop bit. `frame_err` pulses in that same cycle.
- **Holding.** `ps2_key` holds its value between events. Consumers detect a new event by a change in bit [10].
- **Timeout boundary.** If a timeout and a `fall` land on the same cycle, the `fall` wins and the counter clears.
- **Filter rejection.** Glitches shorter than `FILTER_LEN` cycles never produce `fall`.
- **Reset mid-frame.** The partial byte is lost. No event and no `frame_err` are produced for it.
- **Back-to-back frames.** Frames may follow with zero gap. The start bit of the next frame can arrive on the `fall` immediately after STOP.

## Structure
- **Package `ps2_pkg`:**
  - constants `PS2_EXT` = 8'hE0, `PS2_REL` = 8'hF0, `PS2_PAUSE` = 8'hE1, `PS2_PAUSE_SKIP` = 7;
  - frame-state enum {IDLE, DATA, PARITY, STOP}.
- **Sub-module `ps2_pin_filter`:** synchroniser plus counter filter, parameterised by `FILTER_LEN`, reset to 1. It is instantiated once per pin.
- **Top.** The FSM, shifter, timeout counter and prefix logic live in `ps2_key_encoder`.

## Test plan
- **Single make code.** After reset, send frame 0x29 with correct parity → `ps2_key` = 11'h629, `frame_err` stays 0.
- **Break code.** Then send F0, 29 → exactly one update, `ps2_key` = 11'h029.
- **Extended make and break.** Send E0, 75 → `ps2_key` = 11'h775. Then E0, F0, 75 → `ps2_key` = 11'h175.
- **Parity error.** Send 0x1C with wrong parity → `frame_err` pulses for 1 cycle, `ps2_key` unchanged. A following valid 0x1C → `ps2_key` = {~t, 1, 0, 8'h1C}.
- **Timeout and glitch.**
  - Stop the clock after 4 data bits for > `TIMEOUT_CYCLES` → `frame_err` pulses and `busy` falls. A subsequent full frame decodes correctly.
  - A 3-cycle `ps2_clk` glitch → no bit is sampled.
- **Pause and reset.**
  - Send the pause sequence E1 14 77 E1 F0 14 F0 77 → no `ps2_key` change. A next 0x29 gives a normal make event.
  - Assert `reset_n` low mid-frame → all outputs 0 immediately.
